kronos_lsu: RTL and testbench

// Load-store unit downstream of the execute stage. Accepts one memory op at a time from EX and

---
 rtl/kronos_lsu.sv | 164 ++++++++++++++++
 tb/tb_kronos_lsu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/kronos_lsu.sv
// rtl/kronos_lsu.sv - load-store unit: one memory op at a time, bus req/ack, load align/extend, writeback
module kronos_lsu #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        lsu_vld,
    output logic        lsu_rdy,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic        lsu_store,
    input  logic [4:0]  lsu_rd,
    output logic        lsu_done,
    output logic [1:0]  lsu_err,
    output logic [31:0] data_addr,
    input  logic [31:0] data_rd_data,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic        data_ack,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [31:0] TMO_LAST = TIMEOUT - 1;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        wr_en_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [1:0]  err_q;
    logic [31:0] regwr_data_q;
    logic [31:0] cnt_q;

    logic        accept;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  mask_d;
    logic [31:0] wdata_d;

    assign accept      = (state_q == ST_IDLE) && lsu_vld;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        misaligned = 1'b0;
        mask_d     = 4'b1111;
        wdata_d    = lsu_wdata;
        case (lsu_size)
            2'd0: begin
                mask_d  = 4'b0001 << lsu_addr[1:0];
                wdata_d = {4{lsu_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = lsu_addr[0];
                mask_d     = 4'b0011 << lsu_addr[1:0];
                wdata_d    = {2{lsu_wdata[15:0]}};
            end
            2'd2: misaligned = (lsu_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Shift the addressed lane down to bit 0, then sign/zero extend by access size.
    function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    load_align = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_align = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (lsu_vld) state_d = misaligned ? ST_DONE : ST_REQ;
            ST_REQ:  if (data_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lsu_rdy  = (state_q == ST_IDLE);
        data_req = (state_q == ST_REQ);
        lsu_done = (state_q == ST_DONE);
        regwr_en = (state_q == ST_DONE) && !store_q && (err_q == ERR_OK) && (rd_q != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            wr_en_q      <= 1'b0;
            store_q      <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            err_q        <= ERR_OK;
            regwr_data_q <= '0;
            cnt_q        <= '0;
        end else if (accept) begin
            addr_q  <= {lsu_addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            wr_en_q <= lsu_store;
            store_q <= lsu_store;
            size_q  <= lsu_size;
            uns_q   <= lsu_unsigned;
            off_q   <= lsu_addr[1:0];
            rd_q    <= lsu_rd;
            err_q   <= misaligned ? ERR_ALIGN : ERR_OK;
            cnt_q   <= '0;
        end else if (state_q == ST_REQ) begin
            // An ack arriving on the same edge as the timeout still completes the op.
            if (data_ack) begin
                regwr_data_q <= load_align(data_rd_data, off_q, size_q, uns_q);
            end else begin
                cnt_q <= cnt_q + 32'd1;
                if (timeout_hit) err_q <= ERR_TMO;
            end
        end
    end

    assign lsu_err      = err_q;
    assign data_addr    = addr_q;
    assign data_wr_data = wdata_q;
    assign data_mask    = mask_q;
    assign data_wr_en   = wr_en_q;
    assign regwr_data   = regwr_data_q;
    assign regwr_sel    = rd_q;

endmodule

// File: tb/tb_kronos_lsu.sv
// tb/tb_kronos_lsu.sv - directed vector bench for kronos_lsu
module tb_kronos_lsu;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        lsu_vld = 1'b0;
    logic        lsu_rdy;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [1:0]  lsu_size = '0;
    logic        lsu_unsigned = 1'b0;
    logic        lsu_store = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic        lsu_done;
    logic [1:0]  lsu_err;
    logic [31:0] data_addr;
    logic [31:0] data_rd_data = '0;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack = 1'b0;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;

    int checks = 0;
    int errors = 0;

    kronos_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rstz(rstz),
        .lsu_vld(lsu_vld), .lsu_rdy(lsu_rdy), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_store(lsu_store), .lsu_rd(lsu_rd),
        .lsu_done(lsu_done), .lsu_err(lsu_err),
        .data_addr(data_addr), .data_rd_data(data_rd_data), .data_wr_data(data_wr_data),
        .data_mask(data_mask), .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack),
        .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        store;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic        issue;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [1:0]  e_err;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic u, input logic st, input logic [4:0] rd);
        lsu_addr = a; lsu_wdata = wd; lsu_size = sz;
        lsu_unsigned = u; lsu_store = st; lsu_rd = rd;
        lsu_vld = 1'b1;
        step();
        lsu_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        chk("rdy_before", {31'd0, lsu_rdy}, 32'd1);
        issue(v.addr, v.wdata, v.size, v.uns, v.store, v.rd);
        if (v.issue) begin
            chk("req", {31'd0, data_req}, 32'd1);
            chk("addr", data_addr, v.e_addr);
            chk("mask", {28'd0, data_mask}, {28'd0, v.e_mask});
            chk("wdata", data_wr_data, v.e_wdata);
            chk("wr_en", {31'd0, data_wr_en}, {31'd0, v.store});
            for (int i = 1; i < v.dly; i++) begin
                step();
                chk("req_hold", {31'd0, data_req}, 32'd1);
                chk("addr_hold", data_addr, v.e_addr);
            end
            data_ack = 1'b1;
            data_rd_data = v.rdata;
            step();
            data_ack = 1'b0;
            data_rd_data = '0;
        end else begin
            chk("no_req", {31'd0, data_req}, 32'd0);
        end
        chk("done", {31'd0, lsu_done}, 32'd1);
        chk("err", {30'd0, lsu_err}, {30'd0, v.e_err});
        chk("regwr_en", {31'd0, regwr_en}, {31'd0, v.e_wb});
        if (v.e_wb) begin
            chk("regwr_data", regwr_data, v.e_data);
            chk("regwr_sel", {27'd0, regwr_sel}, {27'd0, v.rd});
        end
        step();
        chk("done_clear", {31'd0, lsu_done}, 32'd0);
        chk("req_clear", {31'd0, data_req}, 32'd0);
        chk("rdy_after", {31'd0, lsu_rdy}, 32'd1);
    endtask

    initial begin
        int nreq;
        int ndone;
        // addr wdata size uns store rd rdata dly issue e_addr e_mask e_wdata e_err e_wb e_data
        vecs[0]  = '{32'h100, 32'h0,        2'd2, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 3, 1'b1, 32'h100, 4'hF, 32'h0,        2'd0, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{32'h103, 32'h0,        2'd0, 1'b0, 1'b0, 5'd6,  32'h80FFFFFF, 1, 1'b1, 32'h100, 4'h8, 32'h0,        2'd0, 1'b1, 32'hFFFFFF80};
        vecs[2]  = '{32'h103, 32'h0,        2'd0, 1'b1, 1'b0, 5'd7,  32'h80FFFFFF, 1, 1'b1, 32'h100, 4'h8, 32'h0,        2'd0, 1'b1, 32'h00000080};
        vecs[3]  = '{32'h102, 32'h0,        2'd1, 1'b0, 1'b0, 5'd8,  32'h80011234, 2, 1'b1, 32'h100, 4'hC, 32'h0,        2'd0, 1'b1, 32'hFFFF8001};
        vecs[4]  = '{32'h201, 32'h12345678, 2'd0, 1'b0, 1'b1, 5'd9,  32'h0,        2, 1'b1, 32'h200, 4'h2, 32'h78787878, 2'd0, 1'b0, 32'h0};
        vecs[5]  = '{32'h202, 32'hAABBCCDD, 2'd1, 1'b0, 1'b1, 5'd3,  32'h0,        1, 1'b1, 32'h200, 4'hC, 32'hCCDDCCDD, 2'd0, 1'b0, 32'h0};
        vecs[6]  = '{32'h204, 32'h11223344, 2'd2, 1'b0, 1'b1, 5'd4,  32'h0,        1, 1'b1, 32'h204, 4'hF, 32'h11223344, 2'd0, 1'b0, 32'h0};
        vecs[7]  = '{32'h100, 32'h0,        2'd1, 1'b1, 1'b0, 5'd10, 32'h1234F00D, 1, 1'b1, 32'h100, 4'h3, 32'h0,        2'd0, 1'b1, 32'h0000F00D};
        vecs[8]  = '{32'h101, 32'h0,        2'd0, 1'b0, 1'b0, 5'd11, 32'h00007F00, 2, 1'b1, 32'h100, 4'h2, 32'h0,        2'd0, 1'b1, 32'h0000007F};
        vecs[9]  = '{32'h102, 32'h0,        2'd2, 1'b0, 1'b0, 5'd12, 32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        2'd1, 1'b0, 32'h0};
        vecs[10] = '{32'h101, 32'h5555,     2'd1, 1'b0, 1'b1, 5'd13, 32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        2'd1, 1'b0, 32'h0};
        vecs[11] = '{32'h100, 32'h0,        2'd3, 1'b0, 1'b0, 5'd14, 32'h0,        1, 1'b0, 32'h0,   4'h0, 32'h0,        2'd1, 1'b0, 32'h0};
        vecs[12] = '{32'h104, 32'h0,        2'd2, 1'b0, 1'b0, 5'd0,  32'h00000055, 1, 1'b1, 32'h104, 4'hF, 32'h0,        2'd0, 1'b0, 32'h0};

        rstz = 1'b0;
        step();
        step();
        chk("rst_rdy", {31'd0, lsu_rdy}, 32'd1);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_regwr_en", {31'd0, regwr_en}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_mask", {28'd0, data_mask}, 32'd0);
        chk("rst_err", {30'd0, lsu_err}, 32'd0);
        rstz = 1'b1;
        step();

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Timeout: request stays up exactly TIMEOUT cycles, then err=2.
        issue(32'h300, 32'h0, 2'd2, 1'b0, 1'b0, 5'd15);
        nreq = 0;
        for (int i = 0; i < 20 && !lsu_done; i++) begin
            if (data_req) nreq++;
            step();
        end
        chk("tmo_done", {31'd0, lsu_done}, 32'd1);
        chk("tmo_req_cycles", nreq, 32'd4);
        chk("tmo_err", {30'd0, lsu_err}, 32'd2);
        chk("tmo_regwr_en", {31'd0, regwr_en}, 32'd0);
        step();
        data_ack = 1'b1;
        data_rd_data = 32'hFFFFFFFF;
        step();
        data_ack = 1'b0;
        chk("stray_ack_done", {31'd0, lsu_done}, 32'd0);
        chk("stray_ack_req", {31'd0, data_req}, 32'd0);
        chk("stray_ack_rdy", {31'd0, lsu_rdy}, 32'd1);

        // Reset mid-REQ drops the op; a later ack must not retire anything.
        issue(32'h400, 32'h0, 2'd2, 1'b0, 1'b0, 5'd16);
        chk("mid_req", {31'd0, data_req}, 32'd1);
        rstz = 1'b0;
        step();
        chk("mid_rst_req", {31'd0, data_req}, 32'd0);
        chk("mid_rst_rdy", {31'd0, lsu_rdy}, 32'd1);
        chk("mid_rst_done", {31'd0, lsu_done}, 32'd0);
        rstz = 1'b1;
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            if (lsu_done || regwr_en) ndone++;
            step();
        end
        chk("post_rst_no_done", ndone, 32'd0);
        chk("post_rst_rdy", {31'd0, lsu_rdy}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
